inst_fetch_queue: RTL and testbench
===================================

INST_FETCH_QUEUE -- requirements
Module: inst_fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4: queue entries; power of two, 2..16.
REQ-002 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-003 The clock and reset ports SHALL be:
- clk  in  1  clock; one clock domain.
- rst  in  1  reset; asynchronous, active-high.
REQ-004 The redirect ports SHALL be:
- redirect  in  1  core branch/jump taken; flush and refetch.
- redirect_pc  in  32  new fetch address.
REQ-005 The instruction-memory request ports SHALL be:
- imem_req  out  1  fetch request.
- imem_addr  out  32  word-aligned fetch address.
- imem_gnt  in  1  request accepted this cycle.
REQ-006 The instruction-memory response ports SHALL be:
- imem_rvalid  in  1  response data valid.
- imem_rdata  in  32  fetched instruction.
REQ-007 The core-side ports SHALL be:
- deq_en  in  1  core IF stage consumes the head entry (driven from the IF enable).
- q_valid  out  1  head entry present.
- q_inst  out  32  head instruction.
- q_pc  out  32  head instruction address.
- q_count  out  5  occupied entries.

Function
REQ-008 The fetch FSM SHALL have states IDLE, WAIT and DROP, with at most one request outstanding.
REQ-009 imem_req SHALL be combinational: state==IDLE && q_count<DEPTH && !redirect.
REQ-010 imem_addr SHALL equal the fetch_pc register, with bits [1:0] always 00.
REQ-011 When in IDLE with imem_req && imem_gnt: pend_pc<=fetch_pc; fetch_pc<=fetch_pc+4 (mod 2^32); state<=WAIT.
REQ-012 When in IDLE with imem_req && !imem_gnt: state and fetch_pc SHALL hold, and imem_req stays asserted.
REQ-013 When in WAIT with imem_rvalid and no redirect: push {pend_pc, imem_rdata} at the tail; state<=IDLE.
REQ-014 The next request SHALL be issued no earlier than the cycle after the push.
REQ-015 When in DROP with imem_rvalid: discard the data; state<=IDLE.
REQ-016 The queue SHALL be a circular buffer; head and tail pointers wrap modulo DEPTH.
REQ-017 q_valid SHALL equal (q_count!=0).
REQ-018 q_inst and q_pc SHALL be the head entry, valid in the same cycle as q_valid.
REQ-019 When empty, q_inst SHALL be 32'h0000_0013 (NOP) and q_pc SHALL be 32'h0.
REQ-020 deq_en && q_valid SHALL pop the head at the clock edge; deq_en while empty SHALL be ignored.
REQ-021 A simultaneous push and pop SHALL leave q_count unchanged; both pointers advance.
REQ-022 Push-to-q_valid latency SHALL be one cycle: response at cycle N, entry visible at N+1 (no bypass).
REQ-023 Full: q_count==DEPTH deasserts imem_req; a single outstanding request never overflows the queue.
REQ-024 Redirect SHALL have priority over push, pop and request. At the edge it SHALL:
- set q_count to 0 and both pointers to 0;
- set fetch_pc to {redirect_pc[31:2],2'b00}.
REQ-025 Redirect state transitions SHALL be:
- IDLE -> IDLE;
- WAIT without rvalid -> DROP;
- WAIT with rvalid in the same cycle -> IDLE, data discarded;
- DROP -> DROP (fetch_pc still updated), or IDLE if rvalid arrives in the same cycle, data discarded.
REQ-026 A gnt arriving in the redirect cycle SHALL be ignored; imem_req is low then.

Reset
REQ-027 Reset values SHALL be: fetch_pc=RESET_PC, state=IDLE, pointers=0, q_count=0, q_valid=0, q_inst=32'h13, q_pc=0.
REQ-028 imem_req SHALL be 0 while rst is high.
REQ-029 Reset asserted mid-WAIT SHALL abandon the outstanding request; any later rvalid in IDLE SHALL be ignored.
REQ-030 Queue storage contents SHALL NOT require reset.

Verification
REQ-031 The bench SHALL cover the following scenarios:
- Reset, then gnt=1 and rvalid one cycle after each grant, with deq_en=0 -> imem_addr sequence 0,4,8,C; q_count reaches 4; imem_req drops.
- Full queue, then deq_en=1 for one cycle -> q_pc pops 0; q_count 3; imem_req reasserts the next cycle with address 0x10.
- Redirect to 0x0000_0102 while in WAIT, rvalid arriving two cycles later -> q_count 0; the late data is not pushed; next imem_addr is 0x100.
- Redirect in the same cycle as rvalid -> data dropped; state IDLE; the next request goes to the redirect address.
- q_count=2 with push and deq_en in the same cycle -> q_count stays 2; q_pc advances by 4.
- gnt held low for 5 cycles -> imem_req and imem_addr stable; fetch_pc not advanced; q_valid 0 with q_inst 32'h13.

Source files
------------

// File: rtl/inst_fetch_queue.sv
// Instruction fetch unit: single-outstanding-request fetch FSM feeding a small
// circular queue of {pc, instruction} entries, with redirect flush.
module inst_fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        deq_en,
    output logic        q_valid,
    output logic [31:0] q_inst,
    output logic [31:0] q_pc,
    output logic [4:0]  q_count
);

    localparam int          PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [4:0]  DEPTH_C = 5'(DEPTH);
    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam logic [31:0] ALIGN   = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

    state_t           state, state_next;
    logic [31:0]      fetch_pc;
    logic [31:0]      pend_pc;
    logic [PTR_W-1:0] head, tail;
    logic [4:0]       count;
    logic [31:0]      inst_mem [DEPTH];
    logic [31:0]      pc_mem   [DEPTH];
    logic             grant, push, pop;

    // rst gating keeps the request low for the whole reset pulse, not just after it
    assign imem_req  = !rst && (state == IDLE) && (count < DEPTH_C) && !redirect;
    assign imem_addr = fetch_pc;
    assign grant     = imem_req && imem_gnt;
    assign push      = (state == WAIT) && imem_rvalid && !redirect;
    assign pop       = deq_en && (count != 5'd0) && !redirect;

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (grant) state_next = WAIT;
            // A response always closes the transaction; redirect only decides whether it is kept
            WAIT: begin
                if (imem_rvalid)   state_next = IDLE;
                else if (redirect) state_next = DROP;
            end
            DROP: if (imem_rvalid) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC & ALIGN;
            head     <= '0;
            tail     <= '0;
            count    <= 5'd0;
        end else begin
            state <= state_next;
            if (redirect) begin
                fetch_pc <= redirect_pc & ALIGN;
                head     <= '0;
                tail     <= '0;
                count    <= 5'd0;
            end else begin
                if (grant) fetch_pc <= fetch_pc + 32'd4;
                if (push)  tail     <= tail + 1'b1;
                if (pop)   head     <= head + 1'b1;
                case ({push, pop})
                    2'b10:   count <= count + 5'd1;
                    2'b01:   count <= count - 5'd1;
                    default: count <= count;
                endcase
            end
        end
    end

    // Storage and the pending-address latch carry data only, so they are left unreset
    always_ff @(posedge clk) begin
        if (grant) pend_pc <= fetch_pc;
        if (push) begin
            inst_mem[tail] <= imem_rdata;
            pc_mem[tail]   <= pend_pc;
        end
    end

    assign q_count = count;
    assign q_valid = (count != 5'd0);
    assign q_inst  = q_valid ? inst_mem[head] : NOP;
    assign q_pc    = q_valid ? pc_mem[head]   : 32'h0;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue: a per-cycle vector table plus hand-written
// reset sequences.
module tb_inst_fetch_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        deq_en;
    logic        q_valid;
    logic [31:0] q_inst;
    logic [31:0] q_pc;
    logic [4:0]  q_count;

    int n_cmp = 0;
    int n_bad = 0;

    inst_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .deq_en(deq_en),
        .q_valid(q_valid), .q_inst(q_inst), .q_pc(q_pc), .q_count(q_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic [31:0] rpc;
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic        deq;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_qv;
        logic [31:0] e_inst;
        logic [31:0] e_pc;
        logic [4:0]  e_cnt;
    } vec_t;

    localparam int NV = 33;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic rd, input logic [31:0] rpc, input logic gnt,
                                input logic rv, input logic [31:0] rdata, input logic deq,
                                input logic e_req, input logic [31:0] e_addr, input logic e_qv,
                                input logic [31:0] e_inst, input logic [31:0] e_pc,
                                input logic [4:0] e_cnt);
        vec_t v;
        v.rd = rd; v.rpc = rpc; v.gnt = gnt; v.rv = rv; v.rdata = rdata; v.deq = deq;
        v.e_req = e_req; v.e_addr = e_addr; v.e_qv = e_qv;
        v.e_inst = e_inst; v.e_pc = e_pc; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic e_req, input logic [31:0] e_addr,
                              input logic e_qv, input logic [31:0] e_inst,
                              input logic [31:0] e_pc, input logic [4:0] e_cnt);
        check({tag, ".imem_req"},  {31'b0, imem_req}, {31'b0, e_req});
        check({tag, ".imem_addr"}, imem_addr,         e_addr);
        check({tag, ".q_valid"},   {31'b0, q_valid},  {31'b0, e_qv});
        check({tag, ".q_inst"},    q_inst,            e_inst);
        check({tag, ".q_pc"},      q_pc,              e_pc);
        check({tag, ".q_count"},   {27'b0, q_count},  {27'b0, e_cnt});
    endtask

    task automatic idle_inputs();
        redirect = 0; redirect_pc = 0; imem_gnt = 0;
        imem_rvalid = 0; imem_rdata = 0; deq_en = 0;
    endtask

    localparam logic [31:0] NOP = 32'h13;

    initial begin
        // columns: rd rpc gnt rv rdata deq | req addr qv inst pc cnt
        // fill the queue: addresses 0,4,8,C, then imem_req drops when full
        vecs[0]  = mk(0, 0, 1, 0, 0,     0,  1, 32'h0,  0, NOP,   32'h0, 0);
        vecs[1]  = mk(0, 0, 0, 1, 'hA0,  0,  0, 32'h4,  0, NOP,   32'h0, 0);
        vecs[2]  = mk(0, 0, 1, 0, 0,     0,  1, 32'h4,  1, 'hA0,  32'h0, 1);
        vecs[3]  = mk(0, 0, 0, 1, 'hA1,  0,  0, 32'h8,  1, 'hA0,  32'h0, 1);
        vecs[4]  = mk(0, 0, 1, 0, 0,     0,  1, 32'h8,  1, 'hA0,  32'h0, 2);
        vecs[5]  = mk(0, 0, 0, 1, 'hA2,  0,  0, 32'hC,  1, 'hA0,  32'h0, 2);
        vecs[6]  = mk(0, 0, 1, 0, 0,     0,  1, 32'hC,  1, 'hA0,  32'h0, 3);
        vecs[7]  = mk(0, 0, 0, 1, 'hA3,  0,  0, 32'h10, 1, 'hA0,  32'h0, 3);
        vecs[8]  = mk(0, 0, 1, 0, 0,     0,  0, 32'h10, 1, 'hA0,  32'h0, 4);
        // pop once from full; request reasserts at 0x10
        vecs[9]  = mk(0, 0, 0, 0, 0,     1,  0, 32'h10, 1, 'hA0,  32'h0, 4);
        vecs[10] = mk(0, 0, 1, 0, 0,     0,  1, 32'h10, 1, 'hA1,  32'h4, 3);
        // redirect to 0x102 in WAIT, rvalid two cycles later is dropped
        vecs[11] = mk(1, 32'h102, 0, 0, 0, 0, 0, 32'h14, 1, 'hA1, 32'h4, 3);
        vecs[12] = mk(0, 0, 0, 0, 0,     0,  0, 32'h100, 0, NOP,  32'h0, 0);
        vecs[13] = mk(0, 0, 1, 1, 'hBAD, 0,  0, 32'h100, 0, NOP,  32'h0, 0);
        vecs[14] = mk(0, 0, 1, 0, 0,     0,  1, 32'h100, 0, NOP,  32'h0, 0);
        vecs[15] = mk(0, 0, 0, 1, 'hB0,  0,  0, 32'h104, 0, NOP,  32'h0, 0);
        // redirect coincident with rvalid: data dropped, back in IDLE
        vecs[16] = mk(0, 0, 1, 0, 0,     0,  1, 32'h104, 1, 'hB0, 32'h100, 1);
        vecs[17] = mk(1, 32'h200, 0, 1, 'hBAD, 0, 0, 32'h108, 1, 'hB0, 32'h100, 1);
        // gnt held low five cycles: request and address stable
        vecs[18] = mk(0, 0, 0, 0, 0,     0,  1, 32'h200, 0, NOP,  32'h0, 0);
        vecs[19] = mk(0, 0, 0, 0, 0,     0,  1, 32'h200, 0, NOP,  32'h0, 0);
        vecs[20] = mk(0, 0, 0, 0, 0,     0,  1, 32'h200, 0, NOP,  32'h0, 0);
        vecs[21] = mk(0, 0, 0, 0, 0,     0,  1, 32'h200, 0, NOP,  32'h0, 0);
        vecs[22] = mk(0, 0, 0, 0, 0,     0,  1, 32'h200, 0, NOP,  32'h0, 0);
        // build count 2, then push and pop together
        vecs[23] = mk(0, 0, 1, 0, 0,     0,  1, 32'h200, 0, NOP,  32'h0,   0);
        vecs[24] = mk(0, 0, 0, 1, 'hC0,  0,  0, 32'h204, 0, NOP,  32'h0,   0);
        vecs[25] = mk(0, 0, 1, 0, 0,     0,  1, 32'h204, 1, 'hC0, 32'h200, 1);
        vecs[26] = mk(0, 0, 0, 1, 'hC1,  0,  0, 32'h208, 1, 'hC0, 32'h200, 1);
        vecs[27] = mk(0, 0, 1, 0, 0,     0,  1, 32'h208, 1, 'hC0, 32'h200, 2);
        vecs[28] = mk(0, 0, 0, 1, 'hC2,  1,  0, 32'h20C, 1, 'hC0, 32'h200, 2);
        vecs[29] = mk(0, 0, 0, 0, 0,     0,  1, 32'h20C, 1, 'hC1, 32'h204, 2);
        // redirect with gnt and deq present (both ignored), then deq while empty
        vecs[30] = mk(1, 32'h303, 1, 0, 0, 1, 0, 32'h20C, 1, 'hC1, 32'h204, 2);
        vecs[31] = mk(0, 0, 0, 0, 0,     1,  1, 32'h300, 0, NOP,  32'h0, 0);
        vecs[32] = mk(0, 0, 0, 0, 0,     0,  1, 32'h300, 0, NOP,  32'h0, 0);

        idle_inputs();
        rst = 1'b1;
        #2;
        check_outs("reset", 0, 32'h0, 0, NOP, 32'h0, 0);
        @(posedge clk); #1;
        check_outs("reset_hold", 0, 32'h0, 0, NOP, 32'h0, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < NV; i++) begin
            redirect    = vecs[i].rd;
            redirect_pc = vecs[i].rpc;
            imem_gnt    = vecs[i].gnt;
            imem_rvalid = vecs[i].rv;
            imem_rdata  = vecs[i].rdata;
            deq_en      = vecs[i].deq;
            #1;
            check_outs($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr, vecs[i].e_qv,
                       vecs[i].e_inst, vecs[i].e_pc, vecs[i].e_cnt);
            @(posedge clk); #1;
        end

        // reset asserted while a request is outstanding
        idle_inputs();
        imem_gnt = 1'b1;
        #1;
        check("midwait.req_before", {31'b0, imem_req}, 32'h1);
        @(posedge clk); #1;
        imem_gnt = 1'b0;
        check("midwait.addr_adv", imem_addr, 32'h304);
        rst = 1'b1;
        #1;
        check("midwait.req_in_rst", {31'b0, imem_req}, 32'h0);
        check("midwait.addr_in_rst", imem_addr, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        #1;
        check("midwait.req_after", {31'b0, imem_req}, 32'h1);
        @(posedge clk); #1;
        imem_rvalid = 1'b0;
        #1;
        check("midwait.late_cnt", {27'b0, q_count}, 32'h0);
        check("midwait.late_qv", {31'b0, q_valid}, 32'h0);
        check("midwait.late_inst", q_inst, NOP);
        check("midwait.addr_hold", imem_addr, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
